// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video fetch/mode/render definitions
// Contents: fetch FSM state encoding, byte-lane and BSL bit indices,
//           and the byte-select helper used by the lane mux.
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } fetch_state_e;

  localparam int NUM_LANES = 4;
  localparam int BSL_EVEN  = 0;  // fetch_bsl bit steering lanes 0 and 2
  localparam int BSL_ODD   = 1;  // fetch_bsl bit steering lanes 1 and 3

  // Select the high or low byte of a 16-bit DRAM word.
  function automatic logic [7:0] lane_byte(input logic hi, input logic [15:0] d);
    return hi ? d[15:8] : d[7:0];
  endfunction

endpackage

// File: rtl/video_fetch_lanes.sv
// rtl/video_fetch_lanes.sv - byte-lane mux, temp word and renderer transfer register
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en        DRAM read data valid (lane write enable)
//   sel[3:0]     per-lane write enables
//   bsl[1:0]     byte source select ([0] lanes 0/2, [1] lanes 1/3)
//   data[15:0]   DRAM read data
//   xfer         transfer temp word to fetch_data
//   fetch_data   word presented to the renderer
module video_fetch_lanes
  import video_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  sel,
  input  logic [1:0]  bsl,
  input  logic [15:0] data,
  input  logic        xfer,
  output logic [31:0] fetch_data
);

  logic [31:0] temp_q, temp_d;
  logic [31:0] fetch_data_q;

  // temp_d is the temp word with this cycle's lane write already merged,
  // so a coincident strobe and transfer forwards the new bytes directly.
  always_comb begin
    temp_d = temp_q;
    if (wr_en) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (sel[k]) begin
          temp_d[8*k +: 8] = lane_byte(((k % 2) == 0) ? bsl[BSL_EVEN] : bsl[BSL_ODD], data);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_q       <= '0;
      fetch_data_q <= '0;
    end else begin
      temp_q <= temp_d;
      if (xfer) begin
        fetch_data_q <= temp_d;
      end
    end
  end

  assign fetch_data = fetch_data_q;

endmodule

// File: rtl/video_fetch.sv
// rtl/video_fetch.sv - assembles 16-bit DRAM words into 32-bit renderer words
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   c3                       pixel-clock phase strobe
//   line_start_s, go         start of line pulse, fetch window level
//   fetch_stb                transfer strobe (coincides with c3)
//   fetch_sel, fetch_bsl     lane write enables and byte source select
//   video_next, video_strobe DRAM request accepted, DRAM data valid
//   dram_data                DRAM read data
//   video_req                DRAM cycle request
//   fetch_data               word presented to renderer
//   word_cnt                 words received this line (wrapping)
//   underrun                 sticky per line: transfer while data pending
module video_fetch
  import video_pkg::*;
#(
  parameter int MAX_OUTST = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c3,
  input  logic        line_start_s,
  input  logic        go,
  input  logic        fetch_stb,
  input  logic [3:0]  fetch_sel,
  input  logic [1:0]  fetch_bsl,
  input  logic        video_next,
  input  logic        video_strobe,
  input  logic [15:0] dram_data,
  output logic        video_req,
  output logic [31:0] fetch_data,
  output logic [7:0]  word_cnt,
  output logic        underrun
);

  localparam logic [1:0] OUTST_MAX = 2'(MAX_OUTST);

  fetch_state_e state_q, state_d;
  logic [1:0]   outst_q, outst_d;
  logic [7:0]   word_cnt_q, word_cnt_d;
  logic         underrun_q, underrun_d;

  logic xfer, restart, clear_line, cap, underrun_set;

  // fetch_stb is defined to land on c3; qualifying keeps a stray strobe harmless.
  assign xfer       = fetch_stb & c3;
  assign restart    = line_start_s && (state_q != ST_IDLE);
  assign clear_line = restart || (line_start_s && go && (state_q == ST_IDLE));
  assign cap        = (outst_q == OUTST_MAX);

  video_fetch_lanes u_lanes (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (video_strobe),
    .sel        (fetch_sel),
    .bsl        (fetch_bsl),
    .data       (dram_data),
    .xfer       (xfer),
    .fetch_data (fetch_data)
  );

  // Outstanding request counter: simultaneous accept and data cancel out.
  always_comb begin
    outst_d = outst_q;
    if (video_next && !video_strobe) begin
      if (!cap) outst_d = outst_q + 2'd1;
    end else if (video_strobe && !video_next) begin
      if (outst_q != 2'd0) outst_d = outst_q - 2'd1;
    end
    if (restart) outst_d = '0;
  end

  always_comb begin
    state_d   = state_q;
    video_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (line_start_s && go) state_d = ST_FILL;
      end
      ST_FILL: begin
        video_req = !cap;
        if (!go)               state_d = ST_DRAIN;
        else if (video_strobe) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        video_req = !cap;
        if (!go) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outst_q == 2'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (restart) state_d = go ? ST_FILL : ST_IDLE;
  end

  // Transfer is premature in FILL, or in STREAM when requests are still in flight
  // and this cycle's data has not arrived.
  assign underrun_set = xfer && ((state_q == ST_FILL) ||
                                 ((state_q == ST_STREAM) && (outst_q != 2'd0) && !video_strobe));

  always_comb begin
    word_cnt_d = word_cnt_q;
    underrun_d = underrun_q;
    if (clear_line) begin
      word_cnt_d = '0;
      underrun_d = 1'b0;
    end else begin
      if (video_strobe && (state_q != ST_IDLE)) word_cnt_d = word_cnt_q + 8'd1;
      if (underrun_set) underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      outst_q    <= '0;
      word_cnt_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      outst_q    <= outst_d;
      word_cnt_q <= word_cnt_d;
      underrun_q <= underrun_d;
    end
  end

  assign word_cnt = word_cnt_q;
  assign underrun = underrun_q;

endmodule
